// File: rtl/pwm_sched_pkg.sv
// Shared types and constants for the dual-channel PWM duty scheduler.
package pwm_sched_pkg;

    typedef logic [7:0] duty_t;

    typedef enum logic {
        CH_A = 1'b0,
        CH_B = 1'b1
    } ch_e;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } ch_state_e;

    localparam int    PWM_PERIOD = 256;
    // Counter value on the last cycle of a PWM period
    localparam duty_t PER_LAST   = duty_t'(PWM_PERIOD - 1);

endpackage

// File: rtl/pwm_duty_sched_if.sv
// Command handshake bundle: per-channel target duty commands with valid/ready.
interface pwm_duty_sched_if
    import pwm_sched_pkg::*;
();

    logic  cmd_vld;
    logic  cmd_ch;
    duty_t cmd_duty;
    logic  cmd_rdy;

    modport master (
        output cmd_vld,
        output cmd_ch,
        output cmd_duty,
        input  cmd_rdy
    );

    modport slave (
        input  cmd_vld,
        input  cmd_ch,
        input  cmd_duty,
        output cmd_rdy
    );

endinterface

// File: rtl/duty_ramp.sv
// One PWM channel: pending command slot, target and current duty, IDLE/RAMP FSM.
// Duty only moves on the boundary strobe. With PWM_DUTY_RAMP_EN defined the duty
// slews toward the target by STEP per boundary; otherwise it jumps straight there.
module duty_ramp
    import pwm_sched_pkg::*;
#(
    parameter int STEP = 8
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  boundary,
    input  logic  wr_en,
    input  duty_t wr_duty,
    output logic  pend_full,
    output duty_t duty,
    output logic  settled
);

    localparam logic [8:0] STEP9 = 9'(STEP);

    // Step up, saturating at the target (9-bit sum so 0xF8 + 8 cannot wrap)
    function automatic duty_t ramp_up(input duty_t cur, input duty_t tgt);
        logic [8:0] sum;
        sum = {1'b0, cur} + STEP9;
        return (sum > {1'b0, tgt}) ? tgt : sum[7:0];
    endfunction

    // Step down, saturating at the target (signed difference so it cannot go below 0)
    function automatic duty_t ramp_down(input duty_t cur, input duty_t tgt);
        logic signed [8:0] diff;
        diff = $signed({1'b0, cur}) - $signed(STEP9);
        return (diff < $signed({1'b0, tgt})) ? tgt : diff[7:0];
    endfunction

    duty_t     pend_q, pend_d;
    logic      pend_full_q, pend_full_d;
    duty_t     target_q, target_d;
    duty_t     duty_q, duty_d;
    duty_t     eff_tgt;
    ch_state_e state_q;

    // Next-state for pending slot, target and duty
    always_comb begin
        eff_tgt     = pend_full_q ? pend_q : target_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        target_d    = target_q;
        duty_d      = duty_q;
        if (boundary) begin
            target_d    = eff_tgt;
            pend_full_d = 1'b0;
`ifdef PWM_DUTY_RAMP_EN
            if (duty_q < eff_tgt) begin
                duty_d = ramp_up(duty_q, eff_tgt);
            end else if (duty_q > eff_tgt) begin
                duty_d = ramp_down(duty_q, eff_tgt);
            end
`else
            duty_d = eff_tgt;
`endif
        end
        // The slot is never full when a write arrives, so this cannot clobber a pending value
        if (wr_en) begin
            pend_d      = wr_duty;
            pend_full_d = 1'b1;
        end
    end

    // Control and duty registers, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_full_q <= 1'b0;
            target_q    <= '0;
            duty_q      <= '0;
        end else begin
            pend_full_q <= pend_full_d;
            target_q    <= target_d;
            duty_q      <= duty_d;
        end
    end

    // Pending value is only meaningful while pend_full_q is set, so it needs no reset
    always_ff @(posedge clk) begin
        pend_q <= pend_d;
    end

    // Channel FSM: RAMP from accept until the boundary that lands duty on target with no command pending
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wr_en) begin
                        state_q <= RAMP;
                    end
                end
                RAMP: begin
                    if (boundary && !wr_en && (duty_d == eff_tgt)) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pend_full = pend_full_q;
    assign duty      = duty_q;
    assign settled   = (state_q == IDLE);

endmodule

// File: rtl/pwm_duty_sched.sv
// Dual-channel duty scheduler feeding two pwm8 generators. Holds the shared
// 256-cycle period counter, decodes commands to channel A/B and muxes cmd_rdy.
// Optional slew limiting is selected by the PWM_DUTY_RAMP_EN macro.
module pwm_duty_sched
    import pwm_sched_pkg::*;
#(
    parameter int STEP = 8
) (
    input  logic            clk,
    input  logic            rst,
    pwm_duty_sched_if.slave cmd,
    output duty_t           duty_a,
    output duty_t           duty_b,
    output logic            period_start,
    output logic            settled_a,
    output logic            settled_b
);

    duty_t per_cnt_q, per_cnt_d;
    logic  boundary;
    logic  pend_full_a, pend_full_b;
    logic  accept, wr_en_a, wr_en_b;

    // Free-running period counter, wraps 255 -> 0
    always_comb begin
        per_cnt_d = per_cnt_q + 8'd1;
    end

    // Period counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            per_cnt_q <= '0;
        end else begin
            per_cnt_q <= per_cnt_d;
        end
    end

    assign boundary     = (per_cnt_q == PER_LAST);
    assign period_start = boundary;

    // A full slot blocks only its own channel
    assign cmd.cmd_rdy = (ch_e'(cmd.cmd_ch) == CH_B) ? ~pend_full_b : ~pend_full_a;
    assign accept      = cmd.cmd_vld & cmd.cmd_rdy;
    assign wr_en_a     = accept & (ch_e'(cmd.cmd_ch) == CH_A);
    assign wr_en_b     = accept & (ch_e'(cmd.cmd_ch) == CH_B);

    duty_ramp #(.STEP(STEP)) u_ch_a (
        .clk       (clk),
        .rst       (rst),
        .boundary  (boundary),
        .wr_en     (wr_en_a),
        .wr_duty   (cmd.cmd_duty),
        .pend_full (pend_full_a),
        .duty      (duty_a),
        .settled   (settled_a)
    );

    duty_ramp #(.STEP(STEP)) u_ch_b (
        .clk       (clk),
        .rst       (rst),
        .boundary  (boundary),
        .wr_en     (wr_en_b),
        .wr_duty   (cmd.cmd_duty),
        .pend_full (pend_full_b),
        .duty      (duty_b),
        .settled   (settled_b)
    );

endmodule

// File: tb/tb_pwm_duty_sched.sv
// Bench for pwm_duty_sched. Expected per-boundary duties are queued when a command
// is accepted and popped by a monitor after each period boundary.
module tb_pwm_duty_sched;
    import pwm_sched_pkg::*;

    localparam int TB_STEP = 8;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    duty_t duty_a, duty_b;
    logic  period_start, settled_a, settled_b;

    always #5 clk = ~clk;

    pwm_duty_sched_if cmd_if ();

    pwm_duty_sched #(.STEP(TB_STEP)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd          (cmd_if),
        .duty_a       (duty_a),
        .duty_b       (duty_b),
        .period_start (period_start),
        .settled_a    (settled_a),
        .settled_b    (settled_b)
    );

    int n_vec = 0;
    int n_err = 0;
    int qa[$];
    int qb[$];
    int last_a = 0;
    int last_b = 0;
    bit pend_a = 1'b0;
    bit pend_b = 1'b0;

    task automatic clear_model();
        qa.delete();
        qb.delete();
        last_a = 0;
        last_b = 0;
        pend_a = 1'b0;
        pend_b = 1'b0;
    endtask

    // Replace a channel's expected sequence with the walk from its present duty to tgt
    task automatic push_ramp(input int ch, input int tgt);
        int cur;
        int seq[$];
        cur = (ch == 0) ? last_a : last_b;
`ifdef PWM_DUTY_RAMP_EN
        while (cur != tgt) begin
            if (cur < tgt) cur = (cur + TB_STEP > tgt) ? tgt : cur + TB_STEP;
            else           cur = (cur - TB_STEP < tgt) ? tgt : cur - TB_STEP;
            seq.push_back(cur);
        end
`else
        if (cur != tgt) seq.push_back(tgt);
`endif
        if (ch == 0) begin
            qa = seq;
            pend_a = 1'b1;
        end else begin
            qb = seq;
            pend_b = 1'b1;
        end
    endtask

    // Scoreboard monitor: after each boundary edge compare both duties and settled flags
    always begin : sb_monitor
        @(negedge clk);
        if (!rst && period_start) begin
            @(posedge clk);
            #1;
            pend_a = 1'b0;
            pend_b = 1'b0;
            if (qa.size() > 0) last_a = qa.pop_front();
            if (qb.size() > 0) last_b = qb.pop_front();
            n_vec++;
            if (duty_a !== duty_t'(last_a)) begin
                n_err++;
                $display("FAIL sb_duty_a: got %02h expected %02h", duty_a, last_a[7:0]);
            end
            n_vec++;
            if (duty_b !== duty_t'(last_b)) begin
                n_err++;
                $display("FAIL sb_duty_b: got %02h expected %02h", duty_b, last_b[7:0]);
            end
            n_vec++;
            if (settled_a !== (qa.size() == 0 && !pend_a)) begin
                n_err++;
                $display("FAIL sb_settled_a: got %0b expected %0b", settled_a, (qa.size() == 0 && !pend_a));
            end
            n_vec++;
            if (settled_b !== (qb.size() == 0 && !pend_b)) begin
                n_err++;
                $display("FAIL sb_settled_b: got %0b expected %0b", settled_b, (qb.size() == 0 && !pend_b));
            end
        end
    end

    task automatic send_cmd(input int ch, input int d);
        int c = 0;
        @(negedge clk);
        cmd_if.cmd_vld  = 1'b1;
        cmd_if.cmd_ch   = ch[0];
        cmd_if.cmd_duty = d[7:0];
        #1;
        while (!cmd_if.cmd_rdy && c < 600) begin
            @(negedge clk);
            #1;
            c++;
        end
        if (!cmd_if.cmd_rdy) begin
            n_vec++;
            n_err++;
            $display("FAIL send_cmd_timeout: cmd_rdy stayed %0b, required 1", cmd_if.cmd_rdy);
            cmd_if.cmd_vld = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            cmd_if.cmd_vld = 1'b0;
            push_ramp(ch, d);
            n_vec++;
            if (((ch == 0) ? settled_a : settled_b) !== 1'b0) begin
                n_err++;
                $display("FAIL accept_settled_ch%0d: got 1 required 0", ch);
            end
        end
    endtask

    task automatic wait_drain(input int max_cycles);
        int c = 0;
        while ((qa.size() != 0 || qb.size() != 0) && c < max_cycles) begin
            @(negedge clk);
            c++;
        end
        if (qa.size() != 0 || qb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d/%0d steps left, required 0", qa.size(), qb.size());
        end
    endtask

    task automatic test_reset();
        int c = 0;
        rst = 1'b1;
        cmd_if.cmd_vld  = 1'b0;
        cmd_if.cmd_ch   = 1'b0;
        cmd_if.cmd_duty = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if (duty_a !== 8'h00) begin n_err++; $display("FAIL rst_duty_a: got %02h expected 00", duty_a); end
        n_vec++; if (duty_b !== 8'h00) begin n_err++; $display("FAIL rst_duty_b: got %02h expected 00", duty_b); end
        n_vec++; if (settled_a !== 1'b1) begin n_err++; $display("FAIL rst_settled_a: got %0b expected 1", settled_a); end
        n_vec++; if (settled_b !== 1'b1) begin n_err++; $display("FAIL rst_settled_b: got %0b expected 1", settled_b); end
        n_vec++; if (period_start !== 1'b0) begin n_err++; $display("FAIL rst_period_start: got %0b expected 0", period_start); end
        n_vec++; if (cmd_if.cmd_rdy !== 1'b1) begin n_err++; $display("FAIL rst_rdy_a: got %0b expected 1", cmd_if.cmd_rdy); end
        cmd_if.cmd_ch = 1'b1;
        #1;
        n_vec++; if (cmd_if.cmd_rdy !== 1'b1) begin n_err++; $display("FAIL rst_rdy_b: got %0b expected 1", cmd_if.cmd_rdy); end
        cmd_if.cmd_ch = 1'b0;
        rst = 1'b0;
        do begin
            @(negedge clk);
            c++;
        end while (!period_start && c < 400);
        n_vec++;
        if (c !== 255) begin n_err++; $display("FAIL first_period_start: seen after %0d cycles, expected 255", c); end
        @(negedge clk);
        n_vec++;
        if (period_start !== 1'b0) begin n_err++; $display("FAIL period_start_width: got %0b expected 0", period_start); end
    endtask

    task automatic test_ramp_up();
        send_cmd(0, 'h40);
        wait_drain(20 * 256);
        n_vec++; if (duty_a !== 8'h40) begin n_err++; $display("FAIL ramp_up_final: got %02h expected 40", duty_a); end
        n_vec++; if (settled_a !== 1'b1) begin n_err++; $display("FAIL ramp_up_settled: got %0b expected 1", settled_a); end
        n_vec++; if (duty_b !== 8'h00) begin n_err++; $display("FAIL ramp_up_duty_b: got %02h expected 00", duty_b); end
    endtask

    task automatic test_clamp();
        send_cmd(0, 'h05);
        wait_drain(20 * 256);
        n_vec++; if (duty_a !== 8'h05) begin n_err++; $display("FAIL clamp_low: got %02h expected 05", duty_a); end
        send_cmd(0, 'hF8);
        wait_drain(40 * 256);
        n_vec++; if (duty_a !== 8'hF8) begin n_err++; $display("FAIL clamp_pre_high: got %02h expected f8", duty_a); end
        send_cmd(0, 'hFF);
        wait_drain(4 * 256);
        n_vec++; if (duty_a !== 8'hFF) begin n_err++; $display("FAIL clamp_high: got %02h expected ff", duty_a); end
    endtask

    task automatic test_back_pressure();
        int c = 0;
        bit leak = 1'b0;
        send_cmd(0, 'h20);
        @(negedge clk);
        cmd_if.cmd_vld  = 1'b1;
        cmd_if.cmd_ch   = 1'b0;
        cmd_if.cmd_duty = 8'h80;
        #1;
        n_vec++; if (cmd_if.cmd_rdy !== 1'b0) begin n_err++; $display("FAIL bp_rdy_a_full: got %0b expected 0", cmd_if.cmd_rdy); end
        cmd_if.cmd_ch   = 1'b1;
        cmd_if.cmd_duty = 8'h10;
        #1;
        n_vec++; if (cmd_if.cmd_rdy !== 1'b1) begin n_err++; $display("FAIL bp_rdy_b_free: got %0b expected 1", cmd_if.cmd_rdy); end
        @(posedge clk);
        #1;
        cmd_if.cmd_vld = 1'b0;
        push_ramp(1, 'h10);
        n_vec++; if (settled_b !== 1'b0) begin n_err++; $display("FAIL bp_settled_b: got %0b expected 0", settled_b); end
        @(negedge clk);
        cmd_if.cmd_vld  = 1'b1;
        cmd_if.cmd_ch   = 1'b0;
        cmd_if.cmd_duty = 8'h80;
        #1;
        while (!period_start && c < 300) begin
            if (cmd_if.cmd_rdy) leak = 1'b1;
            @(negedge clk);
            #1;
            c++;
        end
        if (cmd_if.cmd_rdy) leak = 1'b1;
        n_vec++;
        if (!period_start) begin n_err++; $display("FAIL bp_boundary_timeout: period_start 0, required 1"); end
        n_vec++;
        if (leak !== 1'b0) begin n_err++; $display("FAIL bp_rdy_held_low: rdy rose before boundary, required low"); end
        @(negedge clk);
        #1;
        n_vec++; if (cmd_if.cmd_rdy !== 1'b1) begin n_err++; $display("FAIL bp_rdy_after_boundary: got %0b expected 1", cmd_if.cmd_rdy); end
        @(posedge clk);
        #1;
        cmd_if.cmd_vld = 1'b0;
        push_ramp(0, 'h80);
        wait_drain(40 * 256);
        n_vec++; if (duty_a !== 8'h80) begin n_err++; $display("FAIL bp_final_a: got %02h expected 80", duty_a); end
        n_vec++; if (duty_b !== 8'h10) begin n_err++; $display("FAIL bp_final_b: got %02h expected 10", duty_b); end
    endtask

    task automatic test_reset_mid_ramp();
        int c = 0;
        @(negedge clk);
        rst = 1'b1;
        clear_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send_cmd(0, 'hFF);
        while (qa.size() != 0 && last_a != 'h30 && c < 20 * 256) begin
            @(negedge clk);
            c++;
        end
        rst = 1'b1;
        clear_model();
        @(posedge clk);
        #1;
        n_vec++; if (duty_a !== 8'h00) begin n_err++; $display("FAIL mid_rst_duty_a: got %02h expected 00", duty_a); end
        n_vec++; if (settled_a !== 1'b1) begin n_err++; $display("FAIL mid_rst_settled_a: got %0b expected 1", settled_a); end
        n_vec++; if (duty_b !== 8'h00) begin n_err++; $display("FAIL mid_rst_duty_b: got %02h expected 00", duty_b); end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            c = 0;
            do begin
                @(negedge clk);
                c++;
            end while (!period_start && c < 300);
            @(negedge clk);
        end
        n_vec++; if (duty_a !== 8'h00) begin n_err++; $display("FAIL mid_rst_no_step: got %02h expected 00", duty_a); end
    endtask

    task automatic test_jump_b();
        int c = 0;
        int first;
`ifdef PWM_DUTY_RAMP_EN
        first = TB_STEP;
`else
        first = 'hBF;
`endif
        send_cmd(1, 'hBF);
        while (!period_start && c < 300) begin
            @(negedge clk);
            c++;
        end
        @(posedge clk);
        #1;
        n_vec++; if (duty_b !== duty_t'(first)) begin n_err++; $display("FAIL jump_first_b: got %02h expected %02h", duty_b, first[7:0]); end
        @(negedge clk);
        wait_drain(30 * 256);
        n_vec++; if (duty_b !== 8'hBF) begin n_err++; $display("FAIL jump_final_b: got %02h expected bf", duty_b); end
        n_vec++; if (settled_b !== 1'b1) begin n_err++; $display("FAIL jump_settled_b: got %0b expected 1", settled_b); end
        c = 0;
        while (!period_start && c < 300) begin
            @(negedge clk);
            c++;
        end
        @(posedge clk);
        #1;
        n_vec++; if (settled_b !== 1'b1) begin n_err++; $display("FAIL jump_settled_hold_b: got %0b expected 1", settled_b); end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_clamp();
        test_back_pressure();
        test_reset_mid_ramp();
        test_jump_b();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
